// File: rtl/ne16_tcdm_arbiter_pkg.sv
// rtl/ne16_tcdm_arbiter_pkg.sv - shared constants and helpers for the NE16 TCDM arbiter
package ne16_tcdm_arbiter_pkg;

    localparam int NE16_ARB_RR   = 0;
    localparam int NE16_ARB_PRIO = 1;

    // Width of a port ID; a single-port arbiter still carries a 1-bit ID.
    function automatic int ne16_id_width(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

endpackage

// File: rtl/ne16_tcdm_arbiter_id_fifo.sv
// rtl/ne16_tcdm_arbiter_id_fifo.sv - in-order FIFO of issuing-port IDs for response routing
module ne16_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [IW-1:0] push_id_i,
    input  logic          pop_i,
    output logic [IW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ne16_tcdm_arbiter.sv
// rtl/ne16_tcdm_arbiter.sv - N-port TCDM arbiter with in-order response routing
module ne16_tcdm_arbiter
    import ne16_tcdm_arbiter_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int AW        = 32,
    parameter int DW        = 256,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_MODE = NE16_ARB_RR
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_PORTS-1:0]            port_req_i,
    output logic [N_PORTS-1:0]            port_gnt_o,
    input  logic [N_PORTS*AW-1:0]         port_add_i,
    input  logic [N_PORTS-1:0]            port_wen_i,
    input  logic [N_PORTS*DW/8-1:0]       port_be_i,
    input  logic [N_PORTS*DW-1:0]         port_data_i,
    output logic [DW-1:0]                 port_r_data_o,
    output logic [N_PORTS-1:0]            port_r_valid_o,
    output logic                          tcdm_req_o,
    input  logic                          tcdm_gnt_i,
    output logic [AW-1:0]                 tcdm_add_o,
    output logic                          tcdm_wen_o,
    output logic [DW/8-1:0]               tcdm_be_o,
    output logic [DW-1:0]                 tcdm_data_o,
    input  logic [DW-1:0]                 tcdm_r_data_i,
    input  logic                          tcdm_r_valid_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int IW = ne16_id_width(N_PORTS);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int BW = DW / 8;

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] winner;
    logic [IW-1:0] head_id;
    logic          any_req;
    logic          fifo_full, fifo_empty;
    logic          accept;
    logic          rsp_ok;
    logic          err_q, err_d;
    logic [CW-1:0] count;

    function automatic int rr_index(input int base, input int k);
        return (base + k) % N_PORTS;
    endfunction

    assign any_req = |port_req_i;

    // Winner pick: descending scan so the lowest-ranked candidate assigns last and wins.
    always_comb begin
        winner = '0;
        if (PRIO_MODE == NE16_ARB_PRIO) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (port_req_i[i]) winner = IW'(i);
            end
        end else begin
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                if (port_req_i[rr_index(int'(rr_ptr_q), k)]) begin
                    winner = IW'(rr_index(int'(rr_ptr_q), k));
                end
            end
        end
    end

    // Full blocks on the registered count only, so a same-cycle pop cannot unblock.
    assign tcdm_req_o = any_req && !fifo_full;
    assign accept     = tcdm_req_o && tcdm_gnt_i;

    // Request payload mux; forced to zero when idle so the bus is quiet.
    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        if (any_req) begin
            tcdm_add_o  = port_add_i[int'(winner)*AW +: AW];
            tcdm_wen_o  = port_wen_i[winner];
            tcdm_be_o   = port_be_i[int'(winner)*BW +: BW];
            tcdm_data_o = port_data_i[int'(winner)*DW +: DW];
        end
    end

    assign port_gnt_o = accept ? (N_PORTS'(1) << winner) : '0;

    // Response routing: data is broadcast, only the valid is steered to the issuer.
    assign rsp_ok         = tcdm_r_valid_i && !fifo_empty;
    assign port_r_valid_o = rsp_ok ? (N_PORTS'(1) << head_id) : '0;
    assign port_r_data_o  = tcdm_r_data_i;

    // Round-robin pointer moves past the winner on each accepted request.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && PRIO_MODE == NE16_ARB_RR) begin
            rr_ptr_d = (winner == IW'(N_PORTS - 1)) ? '0 : winner + IW'(1);
        end
    end

    // A response with nothing outstanding latches the error until reset.
    always_comb begin
        err_d = err_q || (tcdm_r_valid_i && fifo_empty);
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    ne16_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .IW    (IW),
        .CW    (CW)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (accept),
        .push_id_i (winner),
        .pop_i     (rsp_ok),
        .head_o    (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

    assign outst_o = count;
    assign busy_o  = (count != '0) || any_req;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ne16_tcdm_arbiter.sv
// tb/tb_ne16_tcdm_arbiter.sv - directed self-checking bench for ne16_tcdm_arbiter
module tb_ne16_tcdm_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     port_req;
    logic [NP*AW-1:0]  port_add;
    logic [NP-1:0]     port_wen;
    logic [NP*DW/8-1:0] port_be;
    logic [NP*DW-1:0]  port_data;
    logic              tcdm_gnt;
    logic [DW-1:0]     tcdm_r_data;
    logic              tcdm_r_valid;

    // round-robin, depth 4
    logic [NP-1:0] gnt_a, rv_a;
    logic [DW-1:0] rd_a, wd_a;
    logic          req_a, wen_a, busy_a, err_a;
    logic [AW-1:0] add_a;
    logic [DW/8-1:0] be_a;
    logic [2:0]    outst_a;
    // fixed priority, depth 4
    logic [NP-1:0] gnt_p, rv_p;
    logic [DW-1:0] rd_p, wd_p;
    logic          req_p, wen_p, busy_p, err_p;
    logic [AW-1:0] add_p;
    logic [DW/8-1:0] be_p;
    logic [2:0]    outst_p;
    // round-robin, depth 2
    logic [NP-1:0] gnt_m, rv_m;
    logic [DW-1:0] rd_m, wd_m;
    logic          req_m, wen_m, busy_m, err_m;
    logic [AW-1:0] add_m;
    logic [DW/8-1:0] be_m;
    logic [1:0]    outst_m;

    int n_pass = 0;
    int n_total = 0;

    logic [AW-1:0] addr_tab [NP] = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 32'h0000_0200};
    logic [DW-1:0] rsp_ab;

    always #5 clk = ~clk;

    ne16_tcdm_arbiter #(.N_PORTS(NP), .AW(AW), .DW(DW), .MAX_OUTST(4), .PRIO_MODE(0)) u_rr (
        .clk_i(clk), .rst_i(rst), .port_req_i(port_req), .port_gnt_o(gnt_a),
        .port_add_i(port_add), .port_wen_i(port_wen), .port_be_i(port_be), .port_data_i(port_data),
        .port_r_data_o(rd_a), .port_r_valid_o(rv_a), .tcdm_req_o(req_a), .tcdm_gnt_i(tcdm_gnt),
        .tcdm_add_o(add_a), .tcdm_wen_o(wen_a), .tcdm_be_o(be_a), .tcdm_data_o(wd_a),
        .tcdm_r_data_i(tcdm_r_data), .tcdm_r_valid_i(tcdm_r_valid), .outst_o(outst_a),
        .busy_o(busy_a), .err_o(err_a));

    ne16_tcdm_arbiter #(.N_PORTS(NP), .AW(AW), .DW(DW), .MAX_OUTST(4), .PRIO_MODE(1)) u_prio (
        .clk_i(clk), .rst_i(rst), .port_req_i(port_req), .port_gnt_o(gnt_p),
        .port_add_i(port_add), .port_wen_i(port_wen), .port_be_i(port_be), .port_data_i(port_data),
        .port_r_data_o(rd_p), .port_r_valid_o(rv_p), .tcdm_req_o(req_p), .tcdm_gnt_i(tcdm_gnt),
        .tcdm_add_o(add_p), .tcdm_wen_o(wen_p), .tcdm_be_o(be_p), .tcdm_data_o(wd_p),
        .tcdm_r_data_i(tcdm_r_data), .tcdm_r_valid_i(tcdm_r_valid), .outst_o(outst_p),
        .busy_o(busy_p), .err_o(err_p));

    ne16_tcdm_arbiter #(.N_PORTS(NP), .AW(AW), .DW(DW), .MAX_OUTST(2), .PRIO_MODE(0)) u_m2 (
        .clk_i(clk), .rst_i(rst), .port_req_i(port_req), .port_gnt_o(gnt_m),
        .port_add_i(port_add), .port_wen_i(port_wen), .port_be_i(port_be), .port_data_i(port_data),
        .port_r_data_o(rd_m), .port_r_valid_o(rv_m), .tcdm_req_o(req_m), .tcdm_gnt_i(tcdm_gnt),
        .tcdm_add_o(add_m), .tcdm_wen_o(wen_m), .tcdm_be_o(be_m), .tcdm_data_o(wd_m),
        .tcdm_r_data_i(tcdm_r_data), .tcdm_r_valid_i(tcdm_r_valid), .outst_o(outst_m),
        .busy_o(busy_m), .err_o(err_m));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        port_req = '0;
        tcdm_gnt = 1'b0;
        tcdm_r_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++; if (outst_a !== 3'd0) $display("FAIL reset_outst got %0d want 0", outst_a); else n_pass++;
        n_total++; if (err_a !== 1'b0) $display("FAIL reset_err got %b want 0", err_a); else n_pass++;
        n_total++; if (req_a !== 1'b0 || gnt_a !== 4'b0000 || rv_a !== 4'b0000)
            $display("FAIL reset_outputs got req=%b gnt=%b rv=%b want 0", req_a, gnt_a, rv_a); else n_pass++;
        n_total++; if (add_a !== 32'h0 || busy_a !== 1'b0)
            $display("FAIL reset_idle got add=%h busy=%b want 0", add_a, busy_a); else n_pass++;
        cyc();
    endtask

    task automatic test_single_read();
        do_reset();
        port_req = 4'b0100;
        tcdm_gnt = 1'b1;
        @(negedge clk);
        n_total++; if (gnt_a !== 4'b0100) $display("FAIL single_gnt got %b want 0100", gnt_a); else n_pass++;
        n_total++; if (add_a !== 32'h100 || wen_a !== 1'b1 || req_a !== 1'b1)
            $display("FAIL single_bus got add=%h wen=%b req=%b want 100/1/1", add_a, wen_a, req_a); else n_pass++;
        cyc();
        port_req = '0;
        tcdm_gnt = 1'b0;
        tcdm_r_valid = 1'b1;
        tcdm_r_data = rsp_ab;
        @(negedge clk);
        n_total++; if (outst_a !== 3'd1) $display("FAIL single_outst1 got %0d want 1", outst_a); else n_pass++;
        n_total++; if (rv_a !== 4'b0100) $display("FAIL single_rvalid got %b want 0100", rv_a); else n_pass++;
        n_total++; if (rd_a !== rsp_ab) $display("FAIL single_rdata got %h want %h", rd_a, rsp_ab); else n_pass++;
        cyc();
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        n_total++; if (outst_a !== 3'd0 || err_a !== 1'b0)
            $display("FAIL single_drain got outst=%0d err=%b want 0/0", outst_a, err_a); else n_pass++;
        cyc();
    endtask

    task automatic test_rr_order();
        logic [NP-1:0] exp_g [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                     4'b0100, 4'b1000, 4'b0001, 4'b0100};
        do_reset();
        tcdm_gnt = 1'b1;
        for (int k = 0; k < 9; k++) begin
            port_req = (k < 5) ? 4'b1111 : 4'b1101;
            tcdm_r_valid = (k > 0);
            @(negedge clk);
            n_total++; if (gnt_a !== exp_g[k]) $display("FAIL rr_gnt%0d got %b want %b", k, gnt_a, exp_g[k]); else n_pass++;
            if (k > 0) begin
                n_total++; if (rv_a !== exp_g[k-1]) $display("FAIL rr_route%0d got %b want %b", k, rv_a, exp_g[k-1]); else n_pass++;
            end
            cyc();
        end
        port_req = '0;
        tcdm_r_valid = 1'b1;
        cyc();
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        n_total++; if (outst_a !== 3'd0 || err_a !== 1'b0)
            $display("FAIL rr_drain got outst=%0d err=%b want 0/0", outst_a, err_a); else n_pass++;
        cyc();
    endtask

    task automatic test_prio();
        do_reset();
        tcdm_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            port_req = 4'b1001;
            tcdm_r_valid = (k > 0);
            @(negedge clk);
            n_total++; if (gnt_p !== 4'b0001) $display("FAIL prio_gnt%0d got %b want 0001", k, gnt_p); else n_pass++;
            cyc();
        end
        port_req = 4'b1000;
        @(negedge clk);
        n_total++; if (gnt_p !== 4'b1000) $display("FAIL prio_p3 got %b want 1000", gnt_p); else n_pass++;
        n_total++; if (rv_p !== 4'b0001) $display("FAIL prio_route got %b want 0001", rv_p); else n_pass++;
        cyc();
        port_req = '0;
        cyc();
        tcdm_r_valid = 1'b0;
        cyc();
    endtask

    task automatic test_outst_limit();
        logic [6:0] exp_req = 7'b1100011;
        logic [6:0] rsp_cyc = 7'b0110000;
        int exp_out [7] = '{0, 1, 2, 2, 2, 1, 1};
        do_reset();
        tcdm_gnt = 1'b1;
        port_req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            tcdm_r_valid = rsp_cyc[c];
            @(negedge clk);
            n_total++; if (req_m !== exp_req[c] || gnt_m !== {3'b000, exp_req[c]})
                $display("FAIL limit_req%0d got req=%b gnt=%b want %b", c, req_m, gnt_m, exp_req[c]); else n_pass++;
            n_total++; if (int'(outst_m) != exp_out[c])
                $display("FAIL limit_outst%0d got %0d want %0d", c, outst_m, exp_out[c]); else n_pass++;
            n_total++; if (rv_m !== {3'b000, rsp_cyc[c]})
                $display("FAIL limit_rv%0d got %b want %b", c, rv_m, rsp_cyc[c]); else n_pass++;
            cyc();
        end
        port_req = '0;
        for (int c = 7; c < 11; c++) begin
            tcdm_r_valid = (c >= 9);
            cyc();
        end
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        n_total++; if (outst_m !== 2'd0 || err_m !== 1'b0)
            $display("FAIL limit_drain got outst=%0d err=%b want 0/0", outst_m, err_m); else n_pass++;
        cyc();
    endtask

    task automatic test_gnt_stall();
        do_reset();
        port_req = 4'b0010;
        tcdm_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (gnt_a !== 4'b0000 || req_a !== 1'b1 || add_a !== 32'h80 || outst_a !== 3'd0)
                $display("FAIL stall%0d got gnt=%b req=%b add=%h outst=%0d want 0000/1/80/0",
                         k, gnt_a, req_a, add_a, outst_a); else n_pass++;
            cyc();
        end
        tcdm_gnt = 1'b1;
        @(negedge clk);
        n_total++; if (gnt_a !== 4'b0010) $display("FAIL stall_release got %b want 0010", gnt_a); else n_pass++;
        cyc();
        port_req = '0;
        tcdm_gnt = 1'b0;
        @(negedge clk);
        n_total++; if (outst_a !== 3'd1 || busy_a !== 1'b1)
            $display("FAIL stall_outst got outst=%0d busy=%b want 1/1", outst_a, busy_a); else n_pass++;
        tcdm_r_valid = 1'b1;
        cyc();
        tcdm_r_valid = 1'b0;
        cyc();
    endtask

    task automatic test_err_reset();
        do_reset();
        tcdm_r_valid = 1'b1;
        @(negedge clk);
        n_total++; if (rv_a !== 4'b0000) $display("FAIL err_drop got %b want 0000", rv_a); else n_pass++;
        cyc();
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        n_total++; if (err_a !== 1'b1) $display("FAIL err_set got %b want 1", err_a); else n_pass++;
        port_req = 4'b0001;
        tcdm_gnt = 1'b1;
        cyc();
        cyc();
        port_req = '0;
        tcdm_gnt = 1'b0;
        @(negedge clk);
        n_total++; if (err_a !== 1'b1 || outst_a !== 3'd2)
            $display("FAIL err_hold got err=%b outst=%0d want 1/2", err_a, outst_a); else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (outst_a !== 3'd0 || err_a !== 1'b0)
            $display("FAIL err_reset got outst=%0d err=%b want 0/0", outst_a, err_a); else n_pass++;
        tcdm_r_valid = 1'b1;
        @(negedge clk);
        n_total++; if (rv_a !== 4'b0000) $display("FAIL err_late_rv got %b want 0000", rv_a); else n_pass++;
        cyc();
        tcdm_r_valid = 1'b0;
        @(negedge clk);
        n_total++; if (err_a !== 1'b1) $display("FAIL err_late got %b want 1", err_a); else n_pass++;
        cyc();
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rsp_ab = {32{8'hAB}};
        rst = 1'b1;
        port_req = '0;
        tcdm_gnt = 1'b0;
        tcdm_r_valid = 1'b0;
        tcdm_r_data = '0;
        port_wen = '1;
        port_be = '1;
        for (int i = 0; i < NP; i++) begin
            port_add[i*AW +: AW] = addr_tab[i];
            port_data[i*DW +: DW] = {32{8'(8'h11 * (i + 1))}};
        end
        cyc();
        test_reset();
        test_single_read();
        test_rr_order();
        test_prio();
        test_outst_limit();
        test_gnt_stall();
        test_err_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
